// File: rtl/me_best_select_pkg.sv
// Shared constants, FSM state type and the centre-distance helper for the
// motion-estimation best-candidate selector.
package me_pkg;

    localparam int SAD_W  = 14;
    localparam int CRD_W  = 4;
    localparam int RANGE  = 15;
    localparam int CENTER = 7;

    localparam logic [CRD_W-1:0] CENTER_C = CRD_W'(CENTER);
    localparam logic [CRD_W-1:0] LAST_C   = CRD_W'(RANGE - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

    // Manhattan distance from the zero-motion position; one extra bit holds the sum.
    function automatic logic [CRD_W:0] center_dist(input logic [CRD_W-1:0] x,
                                                   input logic [CRD_W-1:0] y);
        logic [CRD_W:0] dx, dy;
        dx = (x >= CENTER_C) ? {1'b0, x - CENTER_C} : {1'b0, CENTER_C - x};
        dy = (y >= CENTER_C) ? {1'b0, y - CENTER_C} : {1'b0, CENTER_C - y};
        return dx + dy;
    endfunction

endpackage

// File: rtl/me_best_select_if.sv
// Candidate stream in, best-match result out; master is the upstream/driver side.
interface me_best_select_if;
    import me_pkg::*;

    logic             blk_start;
    logic             cand_valid;
    logic [SAD_W-1:0] cand_sad;
    logic             busy;
    logic [SAD_W-1:0] best_sad;
    logic [CRD_W-1:0] best_x;
    logic [CRD_W-1:0] best_y;
    logic             done;

    modport master (output blk_start, cand_valid, cand_sad,
                    input  busy, best_sad, best_x, best_y, done);
    modport slave  (input  blk_start, cand_valid, cand_sad,
                    output busy, best_sad, best_x, best_y, done);
endinterface

// File: rtl/me_best_select_cand_cmp.sv
// Decides whether an incoming candidate displaces the running minimum:
// lower SAD wins, then smaller centre distance, otherwise the earlier one stays.
module me_cand_cmp
    import me_pkg::*;
(
    input  logic [SAD_W-1:0] cand_sad_i,
    input  logic [CRD_W-1:0] cand_x_i,
    input  logic [CRD_W-1:0] cand_y_i,
    input  logic [SAD_W-1:0] run_sad_i,
    input  logic [CRD_W-1:0] run_x_i,
    input  logic [CRD_W-1:0] run_y_i,
    output logic             take_new_o
);
    logic [CRD_W:0] cand_dist, run_dist;

    always_comb begin
        cand_dist  = center_dist(cand_x_i, cand_y_i);
        run_dist   = center_dist(run_x_i, run_y_i);
        take_new_o = (cand_sad_i < run_sad_i) ||
                     ((cand_sad_i == run_sad_i) && (cand_dist < run_dist));
    end
endmodule

// File: rtl/me_best_select.sv
// Scans one search window of SADs in raster order, tracks the minimum and
// publishes it with a one-cycle done pulse after the last candidate.
module me_best_select
    import me_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    me_best_select_if.slave  me_if
);
    state_e           state_q;
    logic             busy_q, done_q;
    logic [SAD_W-1:0] best_sad_q, run_sad_q, run_sad_d;
    logic [CRD_W-1:0] best_x_q, best_y_q;
    logic [CRD_W-1:0] run_x_q, run_y_q, run_x_d, run_y_d;
    logic [CRD_W-1:0] cur_x_q, cur_y_q, cur_x_d, cur_y_d;

    logic             accept, first, last, take_new, take;
    logic [CRD_W-1:0] pos_x, pos_y;

    me_cand_cmp u_cmp (
        .cand_sad_i (me_if.cand_sad),
        .cand_x_i   (pos_x),
        .cand_y_i   (pos_y),
        .run_sad_i  (run_sad_q),
        .run_x_i    (run_x_q),
        .run_y_i    (run_y_q),
        .take_new_o (take_new)
    );

    // A candidate arriving with blk_start is position (0,0) of the new block.
    always_comb begin
        accept = me_if.cand_valid && ((state_q == SCAN) || me_if.blk_start);
        pos_x  = me_if.blk_start ? '0 : cur_x_q;
        pos_y  = me_if.blk_start ? '0 : cur_y_q;
        first  = me_if.blk_start || ((cur_x_q == '0) && (cur_y_q == '0));
        last   = accept && (pos_x == LAST_C) && (pos_y == LAST_C);
        take   = first || take_new;

        run_sad_d = take ? me_if.cand_sad : run_sad_q;
        run_x_d   = take ? pos_x : run_x_q;
        run_y_d   = take ? pos_y : run_y_q;

        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        if (accept) begin
            if (last) begin
                cur_x_d = '0;
                cur_y_d = '0;
            end else if (pos_x == LAST_C) begin
                cur_x_d = '0;
                cur_y_d = pos_y + 1'b1;
            end else begin
                cur_x_d = pos_x + 1'b1;
                cur_y_d = pos_y;
            end
        end else if (me_if.blk_start) begin
            cur_x_d = '0;
            cur_y_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            best_sad_q <= '0;
            best_x_q   <= '0;
            best_y_q   <= '0;
            run_sad_q  <= '0;
            run_x_q    <= '0;
            run_y_q    <= '0;
            cur_x_q    <= '0;
            cur_y_q    <= '0;
        end else begin
            done_q  <= 1'b0;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            if (accept) begin
                run_sad_q <= run_sad_d;
                run_x_q   <= run_x_d;
                run_y_q   <= run_y_d;
            end
            case (state_q)
                IDLE: begin
                    if (me_if.blk_start) begin
                        state_q <= SCAN;
                        busy_q  <= 1'b1;
                    end
                end
                SCAN: begin
                    // blk_start restarts the scan; the aborted block never reports.
                    if (!me_if.blk_start && last) begin
                        state_q    <= DONE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        best_sad_q <= run_sad_d;
                        best_x_q   <= run_x_d;
                        best_y_q   <= run_y_d;
                    end
                end
                DONE: begin
                    if (me_if.blk_start) begin
                        state_q <= SCAN;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign me_if.busy     = busy_q;
    assign me_if.done     = done_q;
    assign me_if.best_sad = best_sad_q;
    assign me_if.best_x   = best_x_q;
    assign me_if.best_y   = best_y_q;
endmodule

// File: tb/tb_me_best_select.sv
// Directed stimulus for me_best_select; expected results are queued at issue
// time and checked by an independent monitor on each done pulse.
module tb_me_best_select;
    import me_pkg::*;

    typedef struct {
        int sad;
        int x;
        int y;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;
    int   sads [225];
    bit   busy_bad;
    exp_t sb [$];

    me_best_select_if bus ();

    me_best_select dut (
        .clk   (clk),
        .rst_n (rst_n),
        .me_if (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("best_sad", int'(bus.best_sad), e.sad);
                chk("best_x", int'(bus.best_x), e.x);
                chk("best_y", int'(bus.best_y), e.y);
            end
        end
    end

    task automatic push(input int s, input int x, input int y);
        exp_t e;
        e.sad = s; e.x = x; e.y = y;
        sb.push_back(e);
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < 225; i++) sads[i] = v;
    endtask

    task automatic setp(input int x, input int y, input int v);
        sads[y*15 + x] = v;
    endtask

    task automatic drive(input bit bs, input bit cv, input int s);
        @(posedge clk);
        #1;
        bus.blk_start  = bs;
        bus.cand_valid = cv;
        bus.cand_sad   = SAD_W'(s);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0);
    endtask

    // Leaves the last candidate on the bus; caller decides what follows.
    task automatic feed(input bit with_cand, input bit gaps, input int n);
        int idx;
        busy_bad = 1'b0;
        if (with_cand) begin
            drive(1'b1, 1'b1, sads[0]);
            idx = 1;
        end else begin
            drive(1'b1, 1'b0, 0);
            idx = 0;
        end
        while (idx < n) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                drive(1'b0, 1'b0, 16383);
                @(negedge clk);
                if (!bus.busy) busy_bad = 1'b1;
            end
            drive(1'b0, 1'b1, sads[idx]);
            @(negedge clk);
            if (!bus.busy) busy_bad = 1'b1;
            idx++;
        end
        chk("busy_during_scan", int'(busy_bad), 0);
    endtask

    initial begin
        bus.blk_start  = 1'b0;
        bus.cand_valid = 1'b0;
        bus.cand_sad   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_best_sad", int'(bus.best_sad), 0);
        chk("rst_best_x", int'(bus.best_x), 0);
        chk("rst_best_y", int'(bus.best_y), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // 1: all equal, centre wins; check latency and pulse width
        fill(100);
        push(100, 7, 7);
        feed(1'b0, 1'b0, 225);
        drive(1'b0, 1'b0, 0);
        chk("t1_done_latency", int'(bus.done), 1);
        chk("t1_busy_fall", int'(bus.busy), 0);
        drive(1'b0, 1'b0, 0);
        chk("t1_done_pulse", int'(bus.done), 0);
        idle(3);

        // 2: single minimum with gaps
        fill(200);
        setp(3, 12, 5);
        push(5, 3, 12);
        feed(1'b0, 1'b1, 225);
        idle(4);

        // 3: equal distance -> earlier; then closer to centre wins
        fill(500);
        setp(0, 0, 9);
        setp(14, 14, 9);
        push(9, 0, 0);
        feed(1'b0, 1'b0, 225);
        idle(3);
        fill(500);
        setp(0, 0, 9);
        setp(6, 7, 9);
        push(9, 6, 7);
        feed(1'b0, 1'b0, 225);
        idle(3);

        // 4: complete block, aborted block, block with max-value SADs
        fill(300);
        setp(1, 1, 20);
        push(20, 1, 1);
        feed(1'b0, 1'b0, 225);
        idle(2);
        fill(1);
        feed(1'b0, 1'b0, 100);
        @(negedge clk);
        chk("t4_hold_sad", int'(bus.best_sad), 20);
        fill(16383);
        setp(10, 2, 40);
        push(40, 10, 2);
        feed(1'b0, 1'b0, 225);
        idle(3);

        // 5: reset mid-scan, then stray candidates without blk_start
        fill(0);
        feed(1'b0, 1'b0, 50);
        @(posedge clk);
        #1 rst_n = 1'b0;
        bus.cand_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t5_rst_busy", int'(bus.busy), 0);
        chk("t5_rst_sad", int'(bus.best_sad), 0);
        chk("t5_rst_x", int'(bus.best_x), 0);
        chk("t5_rst_y", int'(bus.best_y), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 30; i++) drive(1'b0, 1'b1, 0);
        idle(2);
        chk("t5_stray_busy", int'(bus.busy), 0);
        chk("t5_stray_sad", int'(bus.best_sad), 0);

        // 6: blk_start plus candidate in the DONE cycle
        fill(50);
        push(50, 7, 7);
        push(0, 0, 0);
        feed(1'b0, 1'b0, 225);
        fill(300);
        sads[0] = 0;
        feed(1'b1, 1'b0, 225);
        idle(3);
        chk("t6_best_sad", int'(bus.best_sad), 0);
        chk("t6_best_x", int'(bus.best_x), 0);
        chk("t6_best_y", int'(bus.best_y), 0);

        idle(3);
        chk("sb_empty", sb.size(), 0);
        chk("done_count", done_cnt, 8);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
